// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair with a mul/div completion
// tracker. A result that was flushed while in flight is drained and
// discarded, so it never reaches HI/LO.
module hilo_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic        md_done,
    input  logic [63:0] md_hilo,
    input  logic        md_cancel,
    input  logic        wb_we_hi,
    input  logic        wb_we_lo,
    input  logic [31:0] wb_wdata,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        rd_stall,
    output logic        start_block,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       err_next;
    logic       commit;

    // A completion is committed only when the op was not flushed.
    assign commit = (state == BUSY) && md_done && !md_cancel;

    // Next-state, timeout counter and protocol-error detection.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                // Stray md_done and lone md_cancel are ignored here.
                if (md_start) begin
                    state_next = md_cancel ? DRAIN : BUSY;
                    cnt_next   = 8'd0;
                end
            end
            BUSY: begin
                err_next = md_start;
                if (md_done) begin
                    // Committed or (with cancel) discarded; either way done.
                    state_next = IDLE;
                end else if (md_cancel) begin
                    state_next = DRAIN;
                    cnt_next   = 8'd0;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DRAIN: begin
                err_next = md_start;
                if (md_done) begin
                    state_next = IDLE;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Control state, counter and registered error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err   <= err_next;
        end
    end

    // HI/LO update: a committing result overrides any same-cycle MTHI/MTLO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            hi <= md_hilo[63:32];
            lo <= md_hilo[31:0];
        end else begin
            if (wb_we_hi) hi <= wb_wdata;
            if (wb_we_lo) lo <= wb_wdata;
        end
    end

    // Read path with bypass from the completing result, then from write-back.
    always_comb begin
        if (commit) begin
            rd_data = rd_sel ? md_hilo[63:32] : md_hilo[31:0];
        end else if (rd_sel && wb_we_hi) begin
            rd_data = wb_wdata;
        end else if (!rd_sel && wb_we_lo) begin
            rd_data = wb_wdata;
        end else begin
            rd_data = rd_sel ? hi : lo;
        end
    end

    assign rd_stall    = rd_req && (state == BUSY) && !(md_done && !md_cancel);
    assign start_block = (state == DRAIN);
    assign busy        = (state == BUSY) || (state == DRAIN);

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios followed by random
// traffic, compared every cycle against a behavioural model of the unit.
module tb_hilo_unit;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start, md_done, md_cancel;
    logic [63:0] md_hilo;
    logic        wb_we_hi, wb_we_lo;
    logic [31:0] wb_wdata;
    logic        rd_req, rd_sel;
    logic [31:0] rd_data;
    logic        rd_stall, start_block, busy, err;
    logic [31:0] hi, lo;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: an outstanding op, whether it will be thrown away,
    // how long it has been outstanding, and the architectural registers.
    bit          m_pending;
    bit          m_discard;
    int          m_age;
    logic [31:0] m_hi, m_lo;
    bit          m_err;

    hilo_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .md_start(md_start), .md_done(md_done), .md_hilo(md_hilo),
        .md_cancel(md_cancel),
        .wb_we_hi(wb_we_hi), .wb_we_lo(wb_we_lo), .wb_wdata(wb_wdata),
        .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_stall(rd_stall), .start_block(start_block),
        .busy(busy), .hi(hi), .lo(lo), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0;
        m_discard = 0;
        m_age     = 0;
        m_hi      = '0;
        m_lo      = '0;
        m_err     = 0;
    endtask

    // One clock cycle: entered and left at a falling edge. Drives inputs,
    // checks outputs against the model, then advances the model.
    task automatic cycle(input bit start, input bit done, input bit cancel,
                         input logic [63:0] hilo, input bit we_hi, input bit we_lo,
                         input logic [31:0] wdata, input bit req, input bit sel);
        bit          will_commit;
        bit          exp_stall;
        bit          err_nx;
        logic [31:0] exp_data;
        md_start  = start;
        md_done   = done;
        md_cancel = cancel;
        md_hilo   = hilo;
        wb_we_hi  = we_hi;
        wb_we_lo  = we_lo;
        wb_wdata  = wdata;
        rd_req    = req;
        rd_sel    = sel;
        #2;
        will_commit = m_pending && !m_discard && done && !cancel;
        exp_stall   = req && m_pending && !m_discard && !(done && !cancel);
        if (will_commit)   exp_data = sel ? hilo[63:32] : hilo[31:0];
        else if (sel && we_hi)  exp_data = wdata;
        else if (!sel && we_lo) exp_data = wdata;
        else               exp_data = sel ? m_hi : m_lo;

        check_eq("busy", busy, m_pending);
        check_eq("start_block", start_block, m_pending && m_discard);
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
        check_eq("err", err, m_err);
        check_eq("rd_stall", rd_stall, exp_stall);
        if (req && !exp_stall) check_eq("rd_data", rd_data, exp_data);

        err_nx = m_pending && start;
        if (!m_pending) begin
            if (start) begin
                m_pending = 1;
                m_discard = cancel;
                m_age     = 0;
            end
        end else if (done) begin
            m_pending = 0;
        end else if (cancel && !m_discard) begin
            m_discard = 1;
            m_age     = 0;
        end else if (m_age == int'(TMO)) begin
            m_pending = 0;
            err_nx    = 1;
        end else begin
            m_age++;
        end
        if (will_commit) begin
            m_hi = hilo[63:32];
            m_lo = hilo[31:0];
        end else begin
            if (we_hi) m_hi = wdata;
            if (we_lo) m_lo = wdata;
        end
        m_err = err_nx;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        md_start = 0; md_done = 0; md_cancel = 0; md_hilo = '0;
        wb_we_hi = 0; wb_we_lo = 0; wb_wdata = '0;
        rd_req = 1; rd_sel = 0;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_start_block", start_block, 1'b0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_rd_stall", rd_stall, 1'b0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        md_start = 0; md_done = 0; md_cancel = 0; md_hilo = '0;
        wb_we_hi = 0; wb_we_lo = 0; wb_wdata = '0;
        rd_req = 0; rd_sel = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        async_reset();

        // MULT issued at cycle 0, done at cycle 4; MFLO on cycles 2-4.
        cycle(1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 64'd0, 0, 0, 32'd0, 1, 0);
        cycle(0, 0, 0, 64'd0, 0, 0, 32'd0, 1, 0);
        cycle(0, 1, 0, 64'h00000001_FFFFFFFE, 0, 0, 32'd0, 1, 0);
        check_eq("mult_hi", hi, 32'h1);
        check_eq("mult_lo", lo, 32'hFFFFFFFE);
        idle(1);

        // Flush in flight: result arriving later is dropped.
        async_reset();
        cycle(1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
        idle(1);
        cycle(0, 0, 1, 64'd0, 0, 0, 32'd0, 0, 0);
        check_eq("drain_block", start_block, 1'b1);
        cycle(0, 0, 0, 64'd0, 0, 0, 32'd0, 1, 1);
        idle(2);
        cycle(0, 1, 0, 64'hDEADBEEF_00000001, 0, 0, 32'd0, 0, 0);
        check_eq("cancel_busy", busy, 1'b0);
        check_eq("cancel_hi", hi, 32'd0);
        check_eq("cancel_lo", lo, 32'd0);

        // MTHI with same-cycle MFHI.
        cycle(0, 0, 0, 64'd0, 1, 0, 32'h12345678, 1, 1);
        check_eq("mthi_hi", hi, 32'h12345678);
        check_eq("mthi_lo", lo, 32'd0);

        // Commit beats a same-cycle MTLO.
        cycle(1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
        cycle(0, 1, 0, 64'hAAAAAAAA_55555555, 0, 1, 32'h11111111, 1, 0);
        check_eq("ovr_hi", hi, 32'hAAAAAAAA);
        check_eq("ovr_lo", lo, 32'h55555555);

        // Timeout, with a protocol-violating md_start while BUSY.
        cycle(1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
        cycle(1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
        idle(TMO + 4);
        check_eq("tmo_idle", busy, 1'b0);
        check_eq("tmo_hi", hi, 32'hAAAAAAAA);

        // md_start during DRAIN, then DRAIN times out.
        cycle(1, 0, 1, 64'd0, 0, 0, 32'd0, 0, 0);
        cycle(1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
        idle(TMO + 4);

        // Reset mid-BUSY; a later stray md_done must be ignored.
        cycle(0, 0, 0, 64'd0, 1, 1, 32'hCAFEF00D, 0, 0);
        cycle(1, 0, 0, 64'd0, 0, 0, 32'd0, 0, 0);
        idle(2);
        async_reset();
        cycle(0, 1, 0, 64'h01234567_89ABCDEF, 0, 0, 32'd0, 1, 1);
        idle(1);
        check_eq("stray_hi", hi, 32'd0);
        check_eq("stray_lo", lo, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 11) == 0), {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register pair and multiply/divide completion tracker, sitting directly downstream of the EX-stage ALU. It captures the 64-bit mul/div result when the ALU reports completion, and applies MTHI/MTLO writes from write-back. It serves MFHI/MFLO reads with bypassing, and stalls those reads while a multi-cycle operation is in flight. A small state machine also tracks issued operations, so a flushed mul/div cannot corrupt HI/LO when its late result arrives.

## Interface
Parameters:
- TIMEOUT, default 64: max cycles in BUSY without completion before error abort (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- md_start  in  1  one-cycle pulse: EX issued MULT/MULTU/DIV/DIVU.
- md_done  in  1  ALU completion strobe.
- md_hilo  in  64  ALU result {hi, lo}; valid only with md_done.
- md_cancel  in  1  flush of the in-flight mul/div (exception/eret).
- wb_we_hi  in  1  MTHI write enable.
- wb_we_lo  in  1  MTLO write enable.
- wb_wdata  in  32  MTHI/MTLO data.
- rd_req  in  1  MFHI/MFLO read request.
- rd_sel  in  1  0 = LO, 1 = HI.
- rd_data  out  32  read data, combinational.
- rd_stall  out  1  read must be held; combinational.
- start_block  out  1  high in DRAIN; upstream must not pulse md_start.
- busy  out  1  high in BUSY or DRAIN (registered state decode).
- hi, lo  out  32 each  architectural HI/LO registers.
- err  out  1  one-cycle registered pulse on protocol violation or timeout.

## Operation
- States: IDLE, BUSY (result pending, will be committed), DRAIN (result pending, will be discarded).
- IDLE:
  - md_start alone -> BUSY.
  - md_start with md_cancel -> DRAIN.
  - md_done ignored (stray).
  - md_cancel ignored.
- BUSY:
  - md_done without cancel -> {hi, lo} <= md_hilo; -> IDLE.
  - md_cancel without md_done -> DRAIN.
  - md_cancel with md_done -> result discarded; -> IDLE.
  - md_start -> ignored; err pulse.
  - Timeout counter reaches TIMEOUT -> IDLE; err pulse; HI/LO unchanged.
- DRAIN:
  - md_done -> result discarded; -> IDLE.
  - md_start -> ignored; err pulse.
  - Timeout applies as in BUSY.
- Timeout counter: 8-bit. Cleared on entry to BUSY/DRAIN; increments each cycle in BUSY/DRAIN; compared with TIMEOUT.
- MTHI/MTLO: each half written independently when its enable is high, in any state. Both enables high writes wb_wdata to both halves.
- Same-cycle commit and wb write: the md_done commit (BUSY) overrides the wb write for both halves.
- Read path, in priority order:
  1. rd_req in BUSY with md_done and no cancel -> forward md_hilo[63:32] / [31:0].
  2. Selected half's wb enable high -> forward wb_wdata.
  3. Otherwise -> hi / lo register.
- rd_stall = rd_req & BUSY & ~(md_done & ~md_cancel). Reads are never stalled in DRAIN or IDLE.
- When rd_stall is high, rd_data is don't-care.

## Timing
- Reset (rst low, async): state IDLE, hi = 0, lo = 0, counter = 0, err = 0. Hence busy = 0 and start_block = 0.
  - Combinational outputs under reset: rd_stall = 0; rd_data = registered value unless forwarding applies.
- Reset mid-operation discards any pending result. A later md_done arrives in IDLE and is ignored.
- Commit latency: hi/lo reflect md_hilo on the clock edge that samples md_done. Same-cycle reads see the value via the bypass.
- WB write latency: register updates at the next edge; same-cycle read bypassed.
- md_start to BUSY: 1 edge. A single-cycle op (md_done one cycle after md_start) is legal: BUSY for 1 cycle.
- err: asserted the cycle after the violating or timeout edge, for exactly one cycle.

## Test plan
- Reset, then MULT with md_start at cycle 0 and md_done at cycle 4, md_hilo = 0x00000001_FFFFFFFE:
  - -> busy cycles 1-4.
  - -> hi = 0x1, lo = 0xFFFFFFFE from cycle 5.
  - -> MFLO requested cycles 2-4 has rd_stall = 1 on 2-3, rd_data = 0xFFFFFFFE on 4.
- Cancel in flight: md_start, md_cancel two cycles later, md_done at cycle 6 with 0xDEAD_BEEF_0000_0001:
  - -> DRAIN, start_block = 1.
  - -> hi/lo unchanged (0).
  - -> IDLE after cycle 6 edge.
- MTHI 0x12345678 and MFHI in the same cycle:
  - -> rd_data = 0x12345678 with no stall.
  - -> hi = 0x12345678 next cycle, lo unchanged.
- BUSY with md_done (0xAAAA_AAAA_5555_5555) and wb_we_lo (0x11111111) in the same cycle:
  - -> lo = 0x55555555, hi = 0xAAAAAAAA.
- Timeout: TIMEOUT = 8, md_start, no md_done:
  - -> err pulses once ~9 cycles later.
  - -> state IDLE, hi/lo unchanged.
  - -> md_start during BUSY or DRAIN also pulses err.
- Async reset asserted mid-BUSY:
  - -> immediate IDLE, busy = 0, hi = lo = 0.
  - -> subsequent stray md_done ignored.
